// File: rtl/wprcnt_pkg.sv
// Shared types and default sizing for the counter-implementation cross-check sequencer.
package wprcnt_pkg;

    localparam int unsigned WPRCNT_WIDTH = 5;
    localparam int unsigned WPRCNT_ERRW  = 8;
    localparam int unsigned RUN_LEN_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } wprcnt_state_t;

endpackage

// File: rtl/wprcnt_cmp.sv
// Three-way compare of counter outputs against the reference count,
// with a sticky mismatch flag and a saturating failing-cycle counter.
module wprcnt_cmp
    import wprcnt_pkg::*;
#(
    parameter int unsigned WIDTH = WPRCNT_WIDTH,
    parameter int unsigned ERRW  = WPRCNT_ERRW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             cmp_en,
    input  logic [WIDTH-1:0] cnt_a,
    input  logic [WIDTH-1:0] cnt_b,
    input  logic [WIDTH-1:0] cnt_c,
    input  logic [WIDTH-1:0] exp_cnt,
    output logic             mismatch,
    output logic [ERRW-1:0]  err_cnt
);

    logic miss;

    // One failing cycle counts once, however many counters disagree.
    assign miss = cmp_en && ((cnt_a != exp_cnt) || (cnt_b != exp_cnt) || (cnt_c != exp_cnt));

    always_ff @(posedge clock) begin
        if (!reset) begin
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else if (clr) begin
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else if (miss) begin
            mismatch <= 1'b1;
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wprcnt_ctrl.sv
// Sequencer that clears and runs three counter implementations in lockstep,
// tracking a reference count and flagging any divergence.
module wprcnt_ctrl
    import wprcnt_pkg::*;
#(
    parameter int unsigned WIDTH = WPRCNT_WIDTH,
    parameter int unsigned ERRW  = WPRCNT_ERRW
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [RUN_LEN_W-1:0] run_len,
    input  logic [WIDTH-1:0]     cnt_a,
    input  logic [WIDTH-1:0]     cnt_b,
    input  logic [WIDTH-1:0]     cnt_c,
    output logic                 cnt_clr,
    output logic                 cnt_en,
    output logic                 busy,
    output logic                 done,
    output logic                 mismatch,
    output logic [ERRW-1:0]      err_cnt,
    output logic [WIDTH-1:0]     exp_cnt
);

    wprcnt_state_t        state;
    wprcnt_state_t        state_nxt;
    logic [RUN_LEN_W-1:0] run_rem;
    logic                 start_ok;
    logic                 cmp_en;
    logic                 cnt_clr_d;
    logic                 cnt_en_d;
    logic                 busy_d;
    logic                 done_d;

    assign start_ok = (state == ST_IDLE) && start && !stop;
    assign cmp_en   = ((state == ST_RUN) || (state == ST_CHECK)) && !stop;

    // Outputs are decoded from the next state and registered alongside it,
    // so they stay aligned with the state while remaining glitch-free flops.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt_clr <= 1'b0;
            cnt_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt_clr <= cnt_clr_d;
            cnt_en  <= cnt_en_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (run_rem != '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (run_rem == RUN_LEN_W'(1)) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_nxt = stop ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_clr_d = (state_nxt == ST_CLEAR);
        cnt_en_d  = (state_nxt == ST_RUN);
        busy_d    = (state_nxt == ST_CLEAR) || (state_nxt == ST_RUN) || (state_nxt == ST_CHECK);
        done_d    = (state_nxt == ST_DONE);
    end

    // run_rem doubles as the latched run length until RUN starts consuming it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            run_rem <= '0;
            exp_cnt <= '0;
        end else if (start_ok) begin
            run_rem <= run_len;
            exp_cnt <= '0;
        end else begin
            if ((state == ST_RUN) && (run_rem != '0)) begin
                run_rem <= run_rem - 1'b1;
            end
            if (cnt_en) begin
                exp_cnt <= exp_cnt + 1'b1;
            end
        end
    end

    wprcnt_cmp #(
        .WIDTH (WIDTH),
        .ERRW  (ERRW)
    ) u_cmp (
        .clock    (clock),
        .reset    (reset),
        .clr      (start_ok),
        .cmp_en   (cmp_en),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .cnt_c    (cnt_c),
        .exp_cnt  (exp_cnt),
        .mismatch (mismatch),
        .err_cnt  (err_cnt)
    );

endmodule

// File: tb/tb_wprcnt_ctrl.sv
// Directed bench for wprcnt_ctrl with behavioural counters under test and
// an optional off-by-one fault on cnt_b.
module tb_wprcnt_ctrl;

    localparam int unsigned WIDTH = 5;
    localparam int unsigned ERRW  = 8;

    logic             clock   = 1'b0;
    logic             reset   = 1'b0;
    logic             start   = 1'b0;
    logic             stop    = 1'b0;
    logic [7:0]       run_len = 8'd0;
    logic [WIDTH-1:0] ref_cnt = '0;
    logic             b_bump  = 1'b0;
    logic [WIDTH-1:0] cnt_a;
    logic [WIDTH-1:0] cnt_b;
    logic [WIDTH-1:0] cnt_c;
    logic             cnt_clr;
    logic             cnt_en;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic [ERRW-1:0]  err_cnt;
    logic [WIDTH-1:0] exp_cnt;

    int checks   = 0;
    int failures = 0;

    wprcnt_ctrl #(
        .WIDTH (WIDTH),
        .ERRW  (ERRW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .run_len  (run_len),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .cnt_c    (cnt_c),
        .cnt_clr  (cnt_clr),
        .cnt_en   (cnt_en),
        .busy     (busy),
        .done     (done),
        .mismatch (mismatch),
        .err_cnt  (err_cnt),
        .exp_cnt  (exp_cnt)
    );

    always #5 clock = ~clock;

    // Well-behaved counter: clear on cnt_clr, increment on cnt_en.
    always @(posedge clock) begin
        if (cnt_clr) begin
            ref_cnt <= '0;
        end else if (cnt_en) begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    assign cnt_a = ref_cnt;
    assign cnt_b = b_bump ? ref_cnt + 1'b1 : ref_cnt;
    assign cnt_c = ref_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench in the cycle right after the accepting edge (CLEAR).
    task automatic start_run(input logic [7:0] len);
        run_len = len;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic run_watch(input int budget, output int en_n, output int done_n,
                             output int steps, output logic ended, output logic wrapped);
        logic [WIDTH-1:0] prev;
        en_n    = 0;
        done_n  = 0;
        steps   = 0;
        ended   = 1'b0;
        wrapped = 1'b0;
        prev    = exp_cnt;
        for (int i = 0; i < budget; i++) begin
            step();
            steps++;
            if (cnt_en) en_n++;
            if (done) done_n++;
            if ((prev == 5'd31) && (exp_cnt == 5'd0)) wrapped = 1'b1;
            prev = exp_cnt;
            if (!busy) begin
                ended = 1'b1;
                break;
            end
        end
        step();
        if (done) done_n++;
    endtask

    initial begin
        logic [3:0] seq_tbl [7];
        int         en_n;
        int         done_n;
        int         steps;
        logic       ended;
        logic       wrapped;

        // Reset held for two cycles
        reset = 1'b0;
        step();
        step();
        check_eq("rst_outs", {28'd0, cnt_clr, cnt_en, busy, done}, 32'd0);
        check_eq("rst_mismatch", mismatch, 0);
        check_eq("rst_err", err_cnt, 0);
        check_eq("rst_exp", exp_cnt, 0);
        reset = 1'b1;
        step();

        // run_len=3 cycle-by-cycle: {cnt_clr, cnt_en, busy, done} for cycles 1..7
        seq_tbl = '{4'b1010, 4'b0110, 4'b0110, 4'b0110, 4'b0010, 4'b0001, 4'b0000};
        start_run(8'd3);
        for (int c = 0; c < 7; c++) begin
            check_eq($sformatf("seq3_c%0d", c + 1), {28'd0, cnt_clr, cnt_en, busy, done},
                     {28'd0, seq_tbl[c]});
            if (c == 4) check_eq("seq3_exp", exp_cnt, 3);
            if (c < 6) step();
        end
        check_eq("seq3_err", err_cnt, 0);
        check_eq("seq3_mismatch", mismatch, 0);

        // cnt_b off by one for two RUN cycles
        start_run(8'd6);
        step();
        step();
        b_bump = 1'b1;
        step();
        step();
        b_bump = 1'b0;
        run_watch(50, en_n, done_n, steps, ended, wrapped);
        check_eq("bump_end", ended, 1);
        check_eq("bump_mismatch", mismatch, 1);
        check_eq("bump_err", err_cnt, 2);
        check_eq("bump_done", done_n, 1);

        // run_len=40 wraps the reference count; start clears prior errors
        start_run(8'd40);
        check_eq("wrap_clr_mismatch", mismatch, 0);
        check_eq("wrap_clr_err", err_cnt, 0);
        run_watch(100, en_n, done_n, steps, ended, wrapped);
        check_eq("wrap_end", ended, 1);
        check_eq("wrap_en", en_n, 40);
        check_eq("wrap_seen", wrapped, 1);
        check_eq("wrap_exp", exp_cnt, 8);
        check_eq("wrap_mismatch", mismatch, 0);
        check_eq("wrap_done", done_n, 1);

        // Persistent fault: 255 RUN + 1 CHECK compares saturate err_cnt
        b_bump = 1'b1;
        start_run(8'd255);
        run_watch(400, en_n, done_n, steps, ended, wrapped);
        b_bump = 1'b0;
        check_eq("sat_end", ended, 1);
        check_eq("sat_err", err_cnt, 255);
        check_eq("sat_mismatch", mismatch, 1);

        // stop in 3rd RUN cycle, with a fault present in that same cycle
        start_run(8'd10);
        step();
        step();
        step();
        stop   = 1'b1;
        b_bump = 1'b1;
        step();
        stop   = 1'b0;
        b_bump = 1'b0;
        check_eq("stop_busy", busy, 0);
        check_eq("stop_en", cnt_en, 0);
        check_eq("stop_exp", exp_cnt, 3);
        check_eq("stop_err", err_cnt, 0);
        done_n = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) done_n++;
            step();
        end
        check_eq("stop_no_done", done_n, 0);
        check_eq("stop_exp_hold", exp_cnt, 3);

        // run_len=0 goes CLEAR, CHECK, DONE
        start_run(8'd0);
        check_eq("zero_clr", cnt_clr, 1);
        run_watch(20, en_n, done_n, steps, ended, wrapped);
        check_eq("zero_end", ended, 1);
        check_eq("zero_steps", steps, 2);
        check_eq("zero_en", en_n, 0);
        check_eq("zero_exp", exp_cnt, 0);
        check_eq("zero_done", done_n, 1);

        // start with stop in IDLE is ignored
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check_eq("startstop_busy", busy, 0);
        check_eq("startstop_clr", cnt_clr, 0);

        // Reset in the middle of a run
        start_run(8'd10);
        step();
        step();
        step();
        reset = 1'b0;
        step();
        check_eq("midrst_outs", {28'd0, cnt_clr, cnt_en, busy, done}, 32'd0);
        check_eq("midrst_exp", exp_cnt, 0);
        reset = 1'b1;
        done_n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done || busy) done_n++;
        end
        check_eq("midrst_idle", done_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
